vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised raster timing generator; successor to the fixed 640x480@60 generator.
//  Produces hsync/vsync/valid, pixel coordinates and frame/line start pulses for any mode.
//  Adds pixel-clock-enable division, programmable sync polarity, a global enable and a
//  flag delay pipeline that aligns sync/valid with downstream RAM/ROM read latency.
//  Sits between the system clock and the pixel-colour path feeding the VGA DAC pins.
// PARAMETERS
//  H_ACTIVE 640 visible pixels/line;  H_FP 16 front porch;  H_SYNC 96 sync;  H_BP 48 back porch
//  V_ACTIVE 480 visible lines;        V_FP 10;              V_SYNC 2;         V_BP 33
//  HS_POL   0   hsync active level (0=active-low);  VS_POL 0  vsync active level
//  PIX_DIV  1   clk cycles per pixel (>=1)
//  PIPE     0   clk-cycle delay of all flag outputs relative to x_pos/y_pos (0..15)
//  CNT_W    10  counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
// PORTS
//  clk          in   1      system clock
//  rst          in   1      synchronous reset, active-high
//  en           in   1      1=run; 0=freeze divider and counters
//  pix_tick     out  1      1 on the clk where the pixel counter advances
//  x_pos        out  CNT_W  horizontal counter (0..H_ACTIVE-1 = visible)
//  y_pos        out  CNT_W  vertical counter (0..V_ACTIVE-1 = visible)
//  valid        out  1      pixel visible (delayed PIPE clks)
//  hsync        out  1      horizontal sync at HS_POL level when active (delayed PIPE)
//  vsync        out  1      vertical sync at VS_POL level when active (delayed PIPE)
//  line_start   out  1      1-clk pulse, first clk of x_pos==0 (delayed PIPE)
//  frame_start  out  1      1-clk pulse, first clk of x_pos==0,y_pos==0 (delayed PIPE)
// BEHAVIOUR
//  - H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). Order per line/frame:
//    active, front porch, sync, back porch; active region starts at counter 0.
//  - Divider div counts 0..PIX_DIV-1 while en=1; pix_tick = en & (div==PIX_DIV-1).
//    pix_first = en & (div==0). PIX_DIV=1 => pix_tick=pix_first=en.
//  - On pix_tick: h_cnt==H_TOTAL-1 -> h_cnt=0 and v_cnt++ (v_cnt==V_TOTAL-1 -> 0, same clk);
//    else h_cnt++. x_pos/y_pos are the registered counters, no extra latency.
//  - Decode (stage 0): valid=(h<H_ACTIVE)&(v<V_ACTIVE);
//    hs_act = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vs_act same on v only;
//    hsync=hs_act?HS_POL:~HS_POL; vsync likewise; line_start=pix_first&(h==0);
//    frame_start=line_start&(v==0). PIPE=0: outputs are stage 0 directly.
//  - PIPE>0: stage 0 passes through PIPE registers shifting every clk (independent of en/pix_tick).
//  - en=0: counters/div hold; pulses 0; valid/syncs keep decoding frozen counters.
//  - rst=1: div,h_cnt,v_cnt=0; all pipeline stages cleared to inactive; while rst=1 outputs
//    forced: valid=0, hsync=~HS_POL, vsync=~VS_POL, pulses=0, pix_tick=0, x_pos=y_pos=0.
//    Mid-frame rst restarts the frame; first clk after release with en=1 has frame_start
//    (stage 0) and, PIPE>0, cleared inactive flags for PIPE clks.
//  - All arithmetic unsigned CNT_W bits; totals computed at elaboration; $error if
//    H_TOTAL or V_TOTAL > 2**CNT_W, PIX_DIV<1, or PIPE>15.
// TESTING
//  1 Defaults, en=1, 1 frame after rst -> 420000-clk frame period, valid high 307200 clks,
//    800-clk line, hsync low exactly 96 clks beginning when x_pos==656.
//  2 Defaults -> vsync low while y_pos in {490,491} (1600 clks); frame_start once per
//    420000 clks, coincident with x_pos=0,y_pos=0; line_start 525 times per frame.
//  3 PIX_DIV=2 -> pix_tick every 2nd clk, each x_pos value held 2 clks, line=1600 clks,
//    line_start 1 clk wide on first of the two x_pos==0 clks.
//  4 PIPE=3 -> valid rises 3 clks after x_pos=0,y_pos=0; hsync falls 3 clks after x_pos==656;
//    first 3 clks after rst release valid=0, hsync=1.
//  5 en=0 for 50 clks at x_pos=100 -> x_pos stays 100, no pulses; x_pos=101 first pix_tick
//    after en=1; HS_POL=1 build: hsync high only for x_pos 656..751.
//  6 rst pulse at x_pos=300,y_pos=200 -> next clk x_pos=y_pos=0, valid=0, hsync=vsync=1;
//    after release frame_start on first clk, next frame_start 420000 clks later.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel
// clock-enable divider, sync polarity and flag delay line.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIX_DIV  = 1,
  parameter int PIPE     = 0,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             pix_tick,
  output logic [CNT_W-1:0] x_pos,
  output logic [CNT_W-1:0] y_pos,
  output logic             valid,
  output logic             hsync,
  output logic             vsync,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST =
    CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST =
    CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  if (H_TOTAL > 2**CNT_W) begin : g_err_h
    $error("H_TOTAL does not fit in CNT_W bits");
  end
  if (V_TOTAL > 2**CNT_W) begin : g_err_v
    $error("V_TOTAL does not fit in CNT_W bits");
  end
  if (PIX_DIV < 1) begin : g_err_div
    $error("PIX_DIV must be at least 1");
  end
  if (PIPE < 0 || PIPE > 15) begin : g_err_pipe
    $error("PIPE must be in 0..15");
  end

  typedef struct packed {
    logic valid;
    logic hsync;
    logic vsync;
    logic line_start;
    logic frame_start;
  } flags_t;

  localparam flags_t IDLE = '{
    valid: 1'b0,
    hsync: ~HS_POL,
    vsync: ~VS_POL,
    line_start: 1'b0,
    frame_start: 1'b0
  };

  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             div_last;
  logic             first;
  logic             hs_act;
  logic             vs_act;
  flags_t           st0;
  flags_t           fo;
  flags_t           fq;

  assign div_last = (div == DIV_LAST);
  assign first    = en & (div == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      div   <= '0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (en) begin
      div <= div_last ? '0 : div + 1'b1;
      if (div_last) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  assign hs_act = (h_cnt >= HS_BEG) && (h_cnt <= HS_LAST);
  assign vs_act = (v_cnt >= VS_BEG) && (v_cnt <= VS_LAST);

  always_comb begin
    st0             = IDLE;
    st0.valid       = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    st0.hsync       = hs_act ? HS_POL : ~HS_POL;
    st0.vsync       = vs_act ? VS_POL : ~VS_POL;
    st0.line_start  = first && (h_cnt == '0);
    st0.frame_start = first && (h_cnt == '0) && (v_cnt == '0);
  end

  // Delay line runs every clk so flags track fixed memory latency.
  if (PIPE == 0) begin : g_nopipe
    assign fo = st0;
  end else begin : g_pipe
    flags_t dly [PIPE];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < PIPE; i++) dly[i] <= IDLE;
      end else begin
        dly[0] <= st0;
        for (int i = 1; i < PIPE; i++) dly[i] <= dly[i-1];
      end
    end
    assign fo = dly[PIPE-1];
  end

  assign fq          = rst ? IDLE : fo;
  assign valid       = fq.valid;
  assign hsync       = fq.hsync;
  assign vsync       = fq.vsync;
  assign line_start  = fq.line_start;
  assign frame_start = fq.frame_start;
  assign pix_tick    = en & div_last & ~rst;
  assign x_pos       = rst ? '0 : h_cnt;
  assign y_pos       = rst ? '0 : v_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default mode line timing plus a small
// mode exercising divider, delay line, polarity, en and rst.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       pix_tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       valid;
    logic       hsync;
    logic       vsync;
    logic       ls;
    logic       fs;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  obs_t d0, s0, s1, s2, s3;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  vga_timing_gen u_d0 (
    .clk(clk), .rst(rst), .en(en),
    .pix_tick(d0.pix_tick), .x_pos(d0.x), .y_pos(d0.y),
    .valid(d0.valid), .hsync(d0.hsync), .vsync(d0.vsync),
    .line_start(d0.ls), .frame_start(d0.fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) u_s0 (
    .clk(clk), .rst(rst), .en(en),
    .pix_tick(s0.pix_tick), .x_pos(s0.x), .y_pos(s0.y),
    .valid(s0.valid), .hsync(s0.hsync), .vsync(s0.vsync),
    .line_start(s0.ls), .frame_start(s0.fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .PIX_DIV(2)
  ) u_s1 (
    .clk(clk), .rst(rst), .en(en),
    .pix_tick(s1.pix_tick), .x_pos(s1.x), .y_pos(s1.y),
    .valid(s1.valid), .hsync(s1.hsync), .vsync(s1.vsync),
    .line_start(s1.ls), .frame_start(s1.fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .PIPE(3)
  ) u_s2 (
    .clk(clk), .rst(rst), .en(en),
    .pix_tick(s2.pix_tick), .x_pos(s2.x), .y_pos(s2.y),
    .valid(s2.valid), .hsync(s2.hsync), .vsync(s2.vsync),
    .line_start(s2.ls), .frame_start(s2.fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_s3 (
    .clk(clk), .rst(rst), .en(en),
    .pix_tick(s3.pix_tick), .x_pos(s3.x), .y_pos(s3.y),
    .valid(s3.valid), .hsync(s3.hsync), .vsync(s3.vsync),
    .line_start(s3.ls), .frame_start(s3.fs)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input int cyc,
                      input logic got, input logic exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic chkn(input string tag, input int cyc,
                      input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  int h, v, hd, m, hm, vm;
  int d0_hs_low, s0_val, s0_fs, s0_ls, s0_vs_low;
  int cnt, s2_rise;

  initial begin
    d0_hs_low = 0; s0_val = 0; s0_fs = 0; s0_ls = 0; s0_vs_low = 0;
    repeat (3) step();

    chkn("rst_x", 0, {22'd0, d0.x}, 32'd0);
    chkn("rst_y", 0, {22'd0, d0.y}, 32'd0);
    chk1("rst_valid", 0, d0.valid, 1'b0);
    chk1("rst_hsync", 0, d0.hsync, 1'b1);
    chk1("rst_vsync", 0, d0.vsync, 1'b1);
    chk1("rst_tick", 0, d0.pix_tick, 1'b0);
    chk1("rst_fs", 0, d0.fs, 1'b0);
    chk1("rst_ls", 0, d0.ls, 1'b0);
    chk1("rst_s3_hsync", 0, s3.hsync, 1'b0);
    chk1("rst_s3_vsync", 0, s3.vsync, 1'b0);
    chk1("rst_s2_valid", 0, s2.valid, 1'b0);

    rst = 1'b0;
    #1;
    for (int n = 0; n < 1625; n++) begin
      h  = n % 25;
      v  = (n / 25) % 13;
      hd = n % 800;
      chkn("s0_x", n, {22'd0, s0.x}, h);
      chkn("s0_y", n, {22'd0, s0.y}, v);
      chk1("s0_valid", n, s0.valid, h < 16 && v < 8);
      chk1("s0_hsync", n, s0.hsync, !(h >= 18 && h < 21));
      chk1("s0_vsync", n, s0.vsync, !(v >= 9 && v < 11));
      chk1("s0_ls", n, s0.ls, h == 0);
      chk1("s0_fs", n, s0.fs, h == 0 && v == 0);
      chk1("s3_hsync", n, s3.hsync, h >= 18 && h < 21);
      chk1("s3_vsync", n, s3.vsync, v >= 9 && v < 11);
      chkn("s1_x", n, {22'd0, s1.x}, (n / 2) % 25);
      chkn("s1_y", n, {22'd0, s1.y}, (n / 50) % 13);
      chk1("s1_tick", n, s1.pix_tick, (n % 2) == 1);
      chk1("s1_ls", n, s1.ls, (n % 50) == 0);
      chk1("s1_fs", n, s1.fs, (n % 650) == 0);
      if (n < 3) begin
        chk1("s2_valid", n, s2.valid, 1'b0);
        chk1("s2_hsync", n, s2.hsync, 1'b1);
        chk1("s2_fs", n, s2.fs, 1'b0);
      end else begin
        m  = n - 3;
        hm = m % 25;
        vm = (m / 25) % 13;
        chk1("s2_valid", n, s2.valid, hm < 16 && vm < 8);
        chk1("s2_hsync", n, s2.hsync, !(hm >= 18 && hm < 21));
        chk1("s2_fs", n, s2.fs, hm == 0 && vm == 0);
      end
      chkn("s2_x", n, {22'd0, s2.x}, h);
      chkn("d0_x", n, {22'd0, d0.x}, hd);
      chkn("d0_y", n, {22'd0, d0.y}, n / 800);
      chk1("d0_valid", n, d0.valid, hd < 640);
      chk1("d0_hsync", n, d0.hsync, !(hd >= 656 && hd < 752));
      chk1("d0_ls", n, d0.ls, hd == 0);
      chk1("d0_fs", n, d0.fs, n == 0);
      if (!d0.hsync) d0_hs_low++;
      if (s0.valid) s0_val++;
      if (s0.fs) s0_fs++;
      if (s0.ls) s0_ls++;
      if (!s0.vsync) s0_vs_low++;
      step();
    end
    chkn("d0_hs_low_cnt", 1625, d0_hs_low, 192);
    chkn("s0_valid_cnt", 1625, s0_val, 640);
    chkn("s0_fs_cnt", 1625, s0_fs, 5);
    chkn("s0_ls_cnt", 1625, s0_ls, 65);
    chkn("s0_vs_low_cnt", 1625, s0_vs_low, 250);

    repeat (75) step();
    chkn("en_pre_x", 1700, {22'd0, d0.x}, 100);
    en = 1'b0;
    #1;
    for (int k = 0; k < 50; k++) begin
      chkn("en0_d0_x", k, {22'd0, d0.x}, 100);
      chk1("en0_tick", k, d0.pix_tick, 1'b0);
      chk1("en0_s0_ls", k, s0.ls, 1'b0);
      chk1("en0_s0_fs", k, s0.fs, 1'b0);
      chkn("en0_s0_x", k, {22'd0, s0.x}, 0);
      chk1("en0_s0_valid", k, s0.valid, 1'b1);
      step();
    end
    en = 1'b1;
    #1;
    chk1("en1_tick", 0, d0.pix_tick, 1'b1);
    chk1("en1_s0_ls", 0, s0.ls, 1'b1);
    chkn("en1_d0_x", 0, {22'd0, d0.x}, 100);
    step();
    chkn("en1_d0_x_next", 1, {22'd0, d0.x}, 101);
    chkn("en1_s0_x_next", 1, {22'd0, s0.x}, 1);

    repeat (37) step();
    rst = 1'b1;
    #1;
    chkn("mrst_x_now", 0, {22'd0, s0.x}, 0);
    chk1("mrst_valid_now", 0, s0.valid, 1'b0);
    step();
    chkn("mrst_x", 1, {22'd0, s0.x}, 0);
    chkn("mrst_y", 1, {22'd0, s0.y}, 0);
    chk1("mrst_valid", 1, s0.valid, 1'b0);
    chk1("mrst_hsync", 1, s0.hsync, 1'b1);
    chk1("mrst_vsync", 1, s0.vsync, 1'b1);
    chk1("mrst_tick", 1, d0.pix_tick, 1'b0);
    chk1("mrst_s2_valid", 1, s2.valid, 1'b0);
    step();
    rst = 1'b0;
    #1;
    chk1("rel_fs", 0, s0.fs, 1'b1);
    chk1("rel_ls", 0, s0.ls, 1'b1);
    chk1("rel_s2_valid", 0, s2.valid, 1'b0);
    chk1("rel_s2_hsync", 0, s2.hsync, 1'b1);
    chk1("rel_s2_fs", 0, s2.fs, 1'b0);
    cnt = 0;
    s2_rise = -1;
    do begin
      step();
      cnt++;
      if (s2_rise < 0 && s2.valid) s2_rise = cnt;
    end while (!s0.fs && cnt < 1000);
    chkn("rel_frame_period", cnt, cnt, 325);
    chkn("rel_s2_valid_rise", cnt, s2_rise, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
